led_scan_ctrl: RTL and testbench

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/led_pkg.sv | 10 +
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_scan_ctrl.sv | 99 +++++++++
 tb/tb_led_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared widths for the LED scan controller and the downstream LED decoder.
package led_pkg;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned STATE_W = 10;
  localparam int unsigned LED_W   = 17;
  localparam int unsigned NUM_SEL = 8;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [STATE_W-1:0] state_t;
endpackage

// File: rtl/led_tick_gen.sv
// Scan prescaler: counts 0..CLK_DIV-1 while enabled and flags the last count.
// Re-enabling restarts the count from 0 so every step after a pause is full length.
module led_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  // Tick only on a cycle that continues an enabled run; the re-enable cycle counts as 0.
  assign tick = enable && en_q && (cnt_q == LAST);

  // Next count: hold while disabled, restart on re-enable, wrap on tick.
  always_comb begin
    cnt_d = cnt_q;
    en_d  = enable;
    if (enable) begin
      if (!en_q || tick) cnt_d = '0;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter registers; en_q resets high so release does not look like a re-enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end
endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan controller: steps the decoder select through NUM_SEL positions,
// blanks the start of each step, and swaps in new display state only at frame wrap.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_valid,
  output logic [SEL_W-1:0]   led_sel,
  output logic [STATE_W-1:0] state_q,
  output logic               blank,
  output logic               frame_start
);
  localparam int unsigned   BW        = $clog2(BLANK_CYCLES + 2);
  localparam logic [BW-1:0] BLANK_LIM = BW'(BLANK_CYCLES);
  localparam sel_t          SEL_LAST  = SEL_W'(NUM_SEL - 1);

  logic   tick;
  logic   wrap;
  sel_t   led_sel_q, led_sel_d;
  state_t state_d;
  state_t pend_q, pend_d;
  logic   pflag_q, pflag_d;
  logic   blank_q, blank_d;
  logic   fs_q, fs_d;
  logic   en_q, en_d;
  logic [BW-1:0] bidx_q, bidx_d;

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign led_sel     = led_sel_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

  // Step advance, frame-synchronous state load, and blank-window tracking.
  always_comb begin
    led_sel_d = led_sel_q;
    state_d   = state_q;
    pend_d    = pend_q;
    pflag_d   = pflag_q;
    bidx_d    = bidx_q;
    en_d      = enable;
    blank_d   = 1'b1;
    wrap      = tick && (led_sel_q == SEL_LAST);
    fs_d      = wrap;

    if (tick) led_sel_d = led_sel_q + SEL_W'(1);

    // A request on the wrap edge bypasses the pending register.
    if (wrap) begin
      if (state_valid)  state_d = state_in;
      else if (pflag_q) state_d = pend_q;
      pflag_d = 1'b0;
    end else if (state_valid) begin
      pend_d  = state_in;
      pflag_d = 1'b1;
    end

    // bidx counts visible cycles into the step, saturating at the blank limit.
    if (enable) begin
      if (tick || !en_q)          bidx_d = '0;
      else if (bidx_q < BLANK_LIM) bidx_d = bidx_q + BW'(1);
      blank_d = (bidx_d < BLANK_LIM);
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_sel_q <= '0;
      state_q   <= '0;
      pend_q    <= '0;
      pflag_q   <= 1'b0;
      blank_q   <= 1'b1;
      fs_q      <= 1'b0;
      en_q      <= 1'b1;
      bidx_q    <= '0;
    end else begin
      led_sel_q <= led_sel_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      pflag_q   <= pflag_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
      en_q      <= en_d;
      bidx_q    <= bidx_d;
    end
  end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (CLK_DIV=4/BLANK=1 main instance,
// CLK_DIV=2/BLANK=0 secondary instance).
module tb_led_scan_ctrl;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, enable = 1'b0, state_valid = 1'b0;
  logic [9:0] state_in = '0;
  logic [2:0] led_sel;
  logic [9:0] state_q;
  logic       blank, frame_start;

  logic       rst1 = 1'b0, en1 = 1'b1;
  logic [9:0] st_in1 = '0;
  logic [2:0] sel1;
  logic [9:0] stq1;
  logic       blank1, fs1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: step index, cycles elapsed in the step, frame state.
  int         m_sel, m_age;
  logic [9:0] m_st, m_pend;
  bit         m_flag, m_blank, m_fs, m_en;

  always #5 clk = ~clk;

  led_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .state_in(state_in),
    .state_valid(state_valid), .led_sel(led_sel), .state_q(state_q),
    .blank(blank), .frame_start(frame_start)
  );

  led_scan_ctrl #(.CLK_DIV(2), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst1), .enable(en1), .state_in(st_in1),
    .state_valid(1'b0), .led_sel(sel1), .state_q(stq1),
    .blank(blank1), .frame_start(fs1)
  );

  // One clock: drive inputs mid-cycle, advance the model at the edge, settle.
  task automatic cyc(input logic r, input logic en, input logic v, input logic [9:0] d);
    bit wrap;
    @(negedge clk);
    rst_n = r; enable = en; state_valid = v; state_in = d;
    @(posedge clk);
    if (!r) begin
      m_sel = 0; m_age = 0; m_st = '0; m_pend = '0; m_flag = 0;
      m_blank = 1; m_fs = 0; m_en = 1;
    end else if (!en) begin
      m_blank = 1; m_fs = 0; m_en = 0;
      if (v) begin m_pend = d; m_flag = 1; end
    end else begin
      wrap = 0;
      if (!m_en) m_age = 0;
      else begin
        m_age++;
        if (m_age == DIV) begin
          m_age = 0;
          m_sel = (m_sel + 1) % 8;
          wrap  = (m_sel == 0);
        end
      end
      if (wrap) begin
        if (v) m_st = d;
        else if (m_flag) m_st = m_pend;
        m_flag = 0;
      end else if (v) begin
        m_pend = d; m_flag = 1;
      end
      m_fs = wrap; m_blank = (m_age < BLK); m_en = 1;
    end
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 1, 1, 10'h3FF);
    cyc(0, 1, 1, 10'h3FF);
    n_cmp++; if (led_sel !== 3'd0) begin n_bad++; $display("FAIL reset_sel got=%0d exp=0", led_sel); end
    n_cmp++; if (state_q !== 10'h000) begin n_bad++; $display("FAIL reset_state got=%h exp=000", state_q); end
    n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("FAIL reset_blank got=%b exp=1", blank); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    cyc(1, 1, 0, '0);
    n_cmp++; if ({led_sel, frame_start, blank} !== {3'd0, 1'b0, 1'b0})
      begin n_bad++; $display("FAIL release_first got sel=%0d fs=%b blk=%b exp 0/0/0", led_sel, frame_start, blank); end
  endtask

  task automatic test_scan;
    int fs_cnt = 0;
    int last_chg = 0;
    logic [2:0] prev;
    cyc(0, 1, 0, '0);
    prev = led_sel;
    for (int k = 1; k <= 33; k++) begin
      cyc(1, 1, 0, '0);
      n_cmp++;
      if ({led_sel, state_q, blank, frame_start} !== {3'(m_sel), m_st, m_blank, m_fs}) begin
        n_bad++;
        $display("FAIL scan k=%0d got sel=%0d st=%h blk=%b fs=%b exp sel=%0d st=%h blk=%b fs=%b",
                 k, led_sel, state_q, blank, frame_start, m_sel, m_st, m_blank, m_fs);
      end
      if (led_sel !== prev) begin
        n_cmp++;
        if (k - last_chg != DIV) begin n_bad++; $display("FAIL scan_spacing k=%0d got=%0d exp=%0d", k, k - last_chg, DIV); end
        last_chg = k;
        prev = led_sel;
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL scan_fs_count got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_load;
    cyc(0, 1, 0, '0);
    for (int k = 1; k <= 32; k++) begin
      cyc(1, 1, k == 13, (k == 13) ? 10'h2A5 : 10'h000);
      if (k == 31) begin
        n_cmp++; if (state_q !== 10'h000) begin n_bad++; $display("FAIL load_hold got=%h exp=000", state_q); end
      end
    end
    n_cmp++; if ({led_sel, state_q, frame_start} !== {3'd0, 10'h2A5, 1'b1})
      begin n_bad++; $display("FAIL load_wrap got sel=%0d st=%h fs=%b exp 0/2a5/1", led_sel, state_q, frame_start); end
  endtask

  task automatic test_bypass;
    logic [9:0] d;
    cyc(0, 1, 0, '0);
    for (int k = 1; k <= 64; k++) begin
      d = (k == 5) ? 10'h001 : (k == 9) ? 10'h3FF : (k == 64) ? 10'h155 : 10'h000;
      cyc(1, 1, k == 5 || k == 9 || k == 64, d);
      if (k == 32 || k == 63) begin
        n_cmp++; if (state_q !== 10'h3FF) begin n_bad++; $display("FAIL bypass_first k=%0d got=%h exp=3ff", k, state_q); end
      end
    end
    n_cmp++; if (state_q !== 10'h155) begin n_bad++; $display("FAIL bypass_second got=%h exp=155", state_q); end
  endtask

  task automatic test_pause;
    cyc(0, 1, 0, '0);
    for (int k = 1; k <= 22; k++) cyc(1, 1, 0, '0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, k == 4, 10'h0F0);
      n_cmp++; if ({led_sel, blank, frame_start} !== {3'd5, 1'b1, 1'b0})
        begin n_bad++; $display("FAIL pause k=%0d got sel=%0d blk=%b fs=%b exp 5/1/0", k, led_sel, blank, frame_start); end
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 0, '0);
      n_cmp++;
      if (k == 1 && {led_sel, blank} !== {3'd5, 1'b1}) begin n_bad++; $display("FAIL resume_blank got sel=%0d blk=%b exp 5/1", led_sel, blank); end
      if (k == 2 && {led_sel, blank} !== {3'd5, 1'b0}) begin n_bad++; $display("FAIL resume_unblank got sel=%0d blk=%b exp 5/0", led_sel, blank); end
      if (k == 4 && led_sel !== 3'd5) begin n_bad++; $display("FAIL resume_early got=%0d exp=5", led_sel); end
      if (k == 5 && {led_sel, blank} !== {3'd6, 1'b1}) begin n_bad++; $display("FAIL resume_step got sel=%0d blk=%b exp 6/1", led_sel, blank); end
      if (k == 3 && led_sel !== 3'd5) begin n_bad++; $display("FAIL resume_mid got=%0d exp=5", led_sel); end
    end
    // The value captured while paused must appear at the next wrap.
    for (int k = 1; k <= 8; k++) cyc(1, 1, 0, '0);
    n_cmp++; if ({led_sel, state_q} !== {3'd0, 10'h0F0})
      begin n_bad++; $display("FAIL pause_capture got sel=%0d st=%h exp 0/0f0", led_sel, state_q); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 1, 0, '0);
    for (int k = 1; k <= 25; k++) cyc(1, 1, k == 25, 10'h111);
    cyc(0, 1, 0, '0);
    n_cmp++; if ({led_sel, state_q, blank, frame_start} !== {3'd0, 10'h000, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL midreset got sel=%0d st=%h blk=%b fs=%b exp 0/000/1/0", led_sel, state_q, blank, frame_start); end
    for (int k = 1; k <= 32; k++) cyc(1, 1, 0, '0);
    n_cmp++; if ({led_sel, state_q, frame_start} !== {3'd0, 10'h000, 1'b1})
      begin n_bad++; $display("FAIL midreset_noload got sel=%0d st=%h fs=%b exp 0/000/1", led_sel, state_q, frame_start); end
  endtask

  task automatic test_random;
    logic r, e, v;
    cyc(0, 1, 0, '0);
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(99) != 0);
      e = ($urandom_range(9) != 0);
      v = ($urandom_range(7) == 0);
      cyc(r, e, v, 10'($urandom));
      n_cmp++;
      if ({led_sel, state_q, blank, frame_start} !== {3'(m_sel), m_st, m_blank, m_fs}) begin
        n_bad++;
        $display("FAIL random k=%0d got sel=%0d st=%h blk=%b fs=%b exp sel=%0d st=%h blk=%b fs=%b",
                 k, led_sel, state_q, blank, frame_start, m_sel, m_st, m_blank, m_fs);
      end
    end
  endtask

  task automatic test_blank0;
    @(negedge clk); rst1 = 1'b0; en1 = 1'b1;
    @(negedge clk); rst1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({sel1, blank1} !== {3'((k / 2) % 8), 1'b0})
        begin n_bad++; $display("FAIL blank0 k=%0d got sel=%0d blk=%b exp sel=%0d blk=0", k, sel1, blank1, (k / 2) % 8); end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_load;
    test_bypass;
    test_pause;
    test_reset_mid;
    test_random;
    test_blank0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
